// File: rtl/parking_pkg.sv
// Shared types and sensor-pattern constants for the parking gate controller.
package parking_pkg;

  typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3, WAIT} gate_state_t;

  // ab = {outer sensor A, inner sensor B}
  localparam logic [1:0] AB_NONE = 2'b00;
  localparam logic [1:0] AB_A    = 2'b10;
  localparam logic [1:0] AB_B    = 2'b01;
  localparam logic [1:0] AB_BOTH = 2'b11;

endpackage

// File: rtl/parking_occupancy_ctrl_sensor_sync.sv
// Multi-stage flip-flop synchronizer for one asynchronous sensor bit.
module sensor_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sr <= '0;
    else        sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// Lot-gate controller: classifies A/B beam sequences as entries or exits and
// keeps a saturating occupancy count with registered full/empty flags.
module parking_occupancy_ctrl
  import parking_pkg::*;
#(
  parameter int unsigned CAPACITY    = 16,
  parameter int unsigned CNT_W       = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor_a,
  input  logic             sensor_b,
  input  logic             clear,
  output logic [CNT_W-1:0] occupancy,
  output logic             enter_pulse,
  output logic             exit_pulse,
  output logic             full,
  output logic             empty
);

  logic        a_s, b_s;
  logic [1:0]  ab;
  gate_state_t state, state_next;
  logic        entry_evt, exit_evt;
  logic [CNT_W-1:0] occ_next;

  sensor_sync #(.STAGES(SYNC_STAGES)) u_sync_a (.clk(clk), .reset(reset), .d(sensor_a), .q(a_s));
  sensor_sync #(.STAGES(SYNC_STAGES)) u_sync_b (.clk(clk), .reset(reset), .d(sensor_b), .q(b_s));

  assign ab = {a_s, b_s};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     state <= IDLE;
    else if (clear) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    entry_evt  = 1'b0;
    exit_evt   = 1'b0;
    case (state)
      IDLE: if (ab == AB_A) state_next = EN1;
            else if (ab == AB_B) state_next = EX1;
            else if (ab == AB_BOTH) state_next = WAIT;
      EN1:  if (ab == AB_BOTH) state_next = EN2;
            else if (ab == AB_NONE) state_next = IDLE;
            else if (ab == AB_B) state_next = WAIT;
      EN2:  if (ab == AB_B) state_next = EN3;
            else if (ab == AB_A) state_next = EN1;
            else if (ab == AB_NONE) state_next = WAIT;
      EN3:  if (ab == AB_NONE) begin
              state_next = IDLE;
              entry_evt  = 1'b1;
            end
            else if (ab == AB_BOTH) state_next = EN2;
            else if (ab == AB_A) state_next = WAIT;
      EX1:  if (ab == AB_BOTH) state_next = EX2;
            else if (ab == AB_NONE) state_next = IDLE;
            else if (ab == AB_A) state_next = WAIT;
      EX2:  if (ab == AB_A) state_next = EX3;
            else if (ab == AB_B) state_next = EX1;
            else if (ab == AB_NONE) state_next = WAIT;
      EX3:  if (ab == AB_NONE) begin
              state_next = IDLE;
              exit_evt   = 1'b1;
            end
            else if (ab == AB_BOTH) state_next = EX2;
            else if (ab == AB_B) state_next = WAIT;
      WAIT: if (ab == AB_NONE) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next count is computed once so full/empty register in step with occupancy.
  always_comb begin
    occ_next = occupancy;
    if (clear)
      occ_next = '0;
    else if (entry_evt && (occupancy < CNT_W'(CAPACITY)))
      occ_next = occupancy + CNT_W'(1);
    else if (exit_evt && (occupancy != '0))
      occ_next = occupancy - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupancy   <= '0;
      enter_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
      full        <= 1'b0;
      empty       <= 1'b1;
    end else begin
      occupancy   <= occ_next;
      enter_pulse <= entry_evt && !clear;
      exit_pulse  <= exit_evt && !clear;
      full        <= (occ_next == CNT_W'(CAPACITY));
      empty       <= (occ_next == '0);
    end
  end

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Self-checking bench: directed passages plus random sensor walks against a path-walk model.
`timescale 1ns/1ps
module tb_parking_occupancy_ctrl;

  localparam int CAP  = 16;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset, sensor_a, sensor_b, clear;
  logic [4:0] occupancy;
  logic       enter_pulse, exit_pulse, full, empty;

  parking_occupancy_ctrl #(.CAPACITY(CAP), .CNT_W(5), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset), .sensor_a(sensor_a), .sensor_b(sensor_b), .clear(clear),
    .occupancy(occupancy), .enter_pulse(enter_pulse), .exit_pulse(exit_pulse),
    .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a passage is a walk along a 5-point path of ab codes
  // (entry 00,10,11,01,00; exit 00,01,11,10,00); stepping off the path is illegal.
  int entry_path[5] = '{0, 2, 3, 1, 0};
  int exit_path[5]  = '{0, 1, 3, 2, 0};
  int  m_dir, m_pos, m_occ;
  bit  m_bad, m_en, m_ex;
  logic [1:0] pq[$];
  bit  clr_d;
  int  cyc = 0;
  int  n_en = 0, n_ex = 0, last_en_cyc = -1;
  logic [1:0] cur = 2'b00;

  task automatic model_step(input int ab);
    int path[5];
    m_en = 0; m_ex = 0;
    if (m_bad) begin
      if (ab == 0) m_bad = 0;
    end else if (m_pos == 0) begin
      if (ab == 2)      begin m_dir = 1;  m_pos = 1; end
      else if (ab == 1) begin m_dir = -1; m_pos = 1; end
      else if (ab == 3) m_bad = 1;
    end else begin
      path = (m_dir == 1) ? entry_path : exit_path;
      if (ab == path[m_pos]) begin
      end else if (ab == path[m_pos+1]) begin
        m_pos++;
        if (m_pos == 4) begin
          m_pos = 0;
          if (m_dir == 1) begin m_en = 1; if (m_occ < CAP) m_occ++; end
          else            begin m_ex = 1; if (m_occ > 0)   m_occ--; end
        end
      end else if (ab == path[m_pos-1]) m_pos--;
      else begin m_bad = 1; m_pos = 0; end
    end
  endtask

  task automatic model_reset();
    m_dir = 0; m_pos = 0; m_bad = 0; m_occ = 0; m_en = 0; m_ex = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("occupancy", 32'(occupancy), 32'(m_occ));
    chk("enter_pulse", 32'(enter_pulse), 32'(m_en));
    chk("exit_pulse", 32'(exit_pulse), 32'(m_ex));
    chk("full", 32'(full), 32'(m_occ == CAP));
    chk("empty", 32'(empty), 32'(m_occ == 0));
  endtask

  task automatic tick(input logic [1:0] ab, input logic clr);
    logic [1:0] v;
    @(posedge clk); #1;
    cyc++;
    v = pq.pop_front();
    if (clr_d) begin
      m_dir = 0; m_pos = 0; m_bad = 0; m_occ = 0; m_en = 0; m_ex = 0;
    end else model_step(int'(v));
    check_model();
    if (enter_pulse === 1'b1) begin n_en++; last_en_cyc = cyc; end
    if (exit_pulse === 1'b1) n_ex++;
    cur = ab;
    sensor_a = ab[1]; sensor_b = ab[0]; clear = clr;
    pq.push_back(ab);
    clr_d = clr;
  endtask

  task automatic hold(input logic [1:0] ab, input int n);
    repeat (n) tick(ab, 1'b0);
  endtask

  task automatic enter_car();
    hold(2'b10, 3); hold(2'b11, 3); hold(2'b01, 3); hold(2'b00, 4);
  endtask

  task automatic exit_car();
    hold(2'b01, 3); hold(2'b11, 3); hold(2'b10, 3); hold(2'b00, 4);
  endtask

  task automatic do_clear();
    tick(2'b00, 1'b1); hold(2'b00, 4);
  endtask

  // Pulse reset low mid-cycle, confirm outputs drop without a clock edge,
  // keep it low for n edges with pins = ab, then release.
  task automatic async_reset(input logic [1:0] ab, input int n);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("rst_async_occ", 32'(occupancy), 32'd0);
    chk("rst_async_empty", 32'(empty), 32'd1);
    chk("rst_async_full", 32'(full), 32'd0);
    chk("rst_async_pulses", 32'({enter_pulse, exit_pulse}), 32'd0);
    repeat (n) begin
      @(posedge clk); #1;
      cyc++;
      check_model();
      sensor_a = ab[1]; sensor_b = ab[0]; clear = 1'b0; cur = ab;
    end
    reset = 1'b1;
    pq.delete();
    pq.push_back(2'b00); pq.push_back(2'b00); pq.push_back(ab);
    clr_d = 0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int occ0, en0, ex0, t_last00, r, n;
    logic [1:0] nxt;

    // 1. reset
    reset = 1'b0; sensor_a = 1'b0; sensor_b = 1'b0; clear = 1'b0;
    model_reset();
    repeat (2) begin
      @(posedge clk); #1; cyc++;
      check_model();
    end
    reset = 1'b1;
    pq.push_back(2'b00); pq.push_back(2'b00); pq.push_back(2'b00);
    clr_d = 0;
    hold(2'b00, 3);
    chk("reset_occ", 32'(occupancy), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);

    // 2. single entry with latency measurement
    hold(2'b00, 3); hold(2'b10, 3); hold(2'b11, 3); hold(2'b01, 3);
    t_last00 = cyc + 1;
    hold(2'b00, 5);
    chk("entry_latency", 32'(last_en_cyc - t_last00), 32'(SYNC + 1));
    chk("entry_occ", 32'(occupancy), 32'd1);

    // 3. saturation and underflow
    do_clear();
    en0 = n_en;
    repeat (17) enter_car();
    chk("sat_occ17", 32'(occupancy), 32'd16);
    chk("sat_full", 32'(full), 32'd1);
    chk("sat_pulses17", 32'(n_en - en0), 32'd17);
    enter_car();
    chk("sat_pulses18", 32'(n_en - en0), 32'd18);
    chk("sat_occ18", 32'(occupancy), 32'd16);
    ex0 = n_ex;
    repeat (17) exit_car();
    chk("unf_occ", 32'(occupancy), 32'd0);
    chk("unf_empty", 32'(empty), 32'd1);
    chk("unf_pulses", 32'(n_ex - ex0), 32'd17);

    // 4. aborts and illegal change
    enter_car(); enter_car();
    occ0 = int'(occupancy); en0 = n_en; ex0 = n_ex;
    hold(2'b10, 3); hold(2'b00, 4);
    hold(2'b10, 3); hold(2'b11, 3); hold(2'b10, 3); hold(2'b00, 4);
    hold(2'b10, 3); hold(2'b01, 3); hold(2'b00, 4);
    chk("abort_occ", 32'(occupancy), 32'(occ0));
    chk("abort_pulses", 32'((n_en - en0) + (n_ex - ex0)), 32'd0);

    // 5. clear coincident with entry completion at occupancy 5
    do_clear();
    repeat (5) enter_car();
    chk("pre_clear_occ", 32'(occupancy), 32'd5);
    en0 = n_en;
    hold(2'b10, 3); hold(2'b11, 3); hold(2'b01, 3);
    hold(2'b00, 2); tick(2'b00, 1'b1); tick(2'b00, 1'b0);
    chk("clear_occ", 32'(occupancy), 32'd0);
    chk("clear_pulse", 32'(enter_pulse), 32'd0);
    hold(2'b00, 4);
    chk("clear_no_entry", 32'(n_en - en0), 32'd0);

    // 6. async reset during EN2 with occupancy 7
    repeat (7) enter_car();
    chk("pre_rst_occ", 32'(occupancy), 32'd7);
    hold(2'b10, 3); hold(2'b11, 5);
    en0 = n_en; ex0 = n_ex;
    async_reset(2'b01, 2);
    hold(2'b01, 3); hold(2'b00, 5);
    chk("rst_no_pulse", 32'((n_en - en0) + (n_ex - ex0)), 32'd0);
    chk("rst_occ_after", 32'(occupancy), 32'd0);

    // Random sensor walks, mostly single-bit changes, occasional clear
    for (int s = 0; s < 400; s++) begin
      r = int'($urandom_range(99));
      nxt = cur;
      if (r < 85)      nxt[$urandom_range(1)] = ~nxt[$urandom_range(1) == 0 ? 0 : 0];
      else if (r < 93) nxt = ~cur;
      if (r < 85) begin
        nxt = cur;
        if ($urandom_range(1) == 1) nxt[1] = ~cur[1]; else nxt[0] = ~cur[0];
      end
      n = int'($urandom_range(4, 1));
      if (r >= 98) tick(nxt, 1'b1);
      hold(nxt, n);
    end
    hold(2'b00, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
